// File: rtl/urv_trap_ctrl.sv
// Machine-mode trap controller: owns mstatus/mie/mip/mepc/mcause and sequences
// trap entry (exceptions, interrupts) and MRET return alongside the execute stage.
module urv_trap_ctrl #(
    parameter logic [31:0] TRAP_VECTOR    = 32'h0000_0008,
    parameter int unsigned HOLDOFF_CYCLES = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        x_stall_i,
    input  logic        x_kill_i,
    input  logic        x_valid_i,
    input  logic [31:0] x_pc_i,
    input  logic        x_exception_i,
    input  logic [3:0]  x_exception_cause_i,
    input  logic        x_is_mret_i,
    input  logic        d_is_csr_i,
    input  logic [11:0] d_csr_sel_i,
    input  logic [31:0] x_csr_write_value_i,
    input  logic        irq_i,
    input  logic        timer_tick_i,
    output logic [31:0] csr_mstatus_o,
    output logic [31:0] csr_mip_o,
    output logic [31:0] csr_mie_o,
    output logic [31:0] csr_mepc_o,
    output logic [31:0] csr_mcause_o,
    output logic        x_trap_o,
    output logic [31:0] x_trap_pc_o,
    output logic        x_mret_o
);

    localparam logic [11:0] CsrMstatus = 12'h300;
    localparam logic [11:0] CsrMie     = 12'h304;
    localparam logic [11:0] CsrMepc    = 12'h341;
    localparam logic [11:0] CsrMcause  = 12'h342;
    localparam logic [3:0]  HoldoffLd  = 4'(HOLDOFF_CYCLES - 1);

    typedef enum logic [0:0] {StRun, StHoldoff} state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        status_mie_q, status_mie_d;
    logic        status_mpie_q, status_mpie_d;
    logic        mie_mtie_q, mie_mtie_d;
    logic        mie_meie_q, mie_meie_d;
    logic        mtip_q, mtip_d;
    logic        meip_q;
    logic [31:0] mepc_q, mepc_d;
    logic        mcause_int_q, mcause_int_d;
    logic [3:0]  mcause_code_q, mcause_code_d;

    logic commit, ext_req, tmr_req, int_req;
    logic take_exc, take_int, take_trap, take_mret, csr_we;

    // Reset also masks commit so no trap or MRET is signalled during a reset cycle.
    assign commit    = x_valid_i & ~x_stall_i & ~x_kill_i & ~rst_i;
    assign ext_req   = meip_q & mie_meie_q;
    assign tmr_req   = mtip_q & mie_mtie_q;
    assign int_req   = status_mie_q & (ext_req | tmr_req);
    assign take_exc  = commit & x_exception_i;
    assign take_int  = commit & ~x_exception_i & int_req & (state_q == StRun);
    assign take_trap = take_exc | take_int;
    assign take_mret = commit & ~take_trap & x_is_mret_i;
    assign csr_we    = commit & ~take_trap & ~take_mret & d_is_csr_i;

    always_comb begin
        status_mie_d  = status_mie_q;
        status_mpie_d = status_mpie_q;
        mie_mtie_d    = mie_mtie_q;
        mie_meie_d    = mie_meie_q;
        mepc_d        = mepc_q;
        mcause_int_d  = mcause_int_q;
        mcause_code_d = mcause_code_q;
        state_d       = state_q;
        cnt_d         = cnt_q;

        // A new tick wins over the clear from a timer trap taken this cycle.
        mtip_d = timer_tick_i | (mtip_q & ~(take_int & ~ext_req));

        if (take_trap) begin
            mepc_d        = x_pc_i & 32'hFFFF_FFFC;
            status_mpie_d = status_mie_q;
            status_mie_d  = 1'b0;
            if (take_exc) begin
                mcause_int_d  = 1'b0;
                mcause_code_d = x_exception_cause_i;
            end else begin
                mcause_int_d  = 1'b1;
                mcause_code_d = ext_req ? 4'd11 : 4'd7;
            end
        end else if (take_mret) begin
            status_mie_d  = status_mpie_q;
            status_mpie_d = 1'b1;
        end else if (csr_we) begin
            case (d_csr_sel_i)
                CsrMstatus: begin
                    status_mie_d  = x_csr_write_value_i[3];
                    status_mpie_d = x_csr_write_value_i[7];
                end
                CsrMie: begin
                    mie_mtie_d = x_csr_write_value_i[7];
                    mie_meie_d = x_csr_write_value_i[11];
                end
                CsrMepc:   mepc_d = x_csr_write_value_i & 32'hFFFF_FFFC;
                CsrMcause: begin
                    mcause_int_d  = x_csr_write_value_i[31];
                    mcause_code_d = x_csr_write_value_i[3:0];
                end
                default: ;
            endcase
        end

        if (take_trap || take_mret) begin
            state_d = StHoldoff;
            cnt_d   = HoldoffLd;
        end else if (state_q == StHoldoff) begin
            if (cnt_q == 4'd0) begin
                state_d = StRun;
            end else begin
                cnt_d = cnt_q - 4'd1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= StRun;
            cnt_q         <= 4'd0;
            status_mie_q  <= 1'b0;
            status_mpie_q <= 1'b0;
            mie_mtie_q    <= 1'b0;
            mie_meie_q    <= 1'b0;
            mtip_q        <= 1'b0;
            meip_q        <= 1'b0;
            mepc_q        <= 32'd0;
            mcause_int_q  <= 1'b0;
            mcause_code_q <= 4'd0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            status_mie_q  <= status_mie_d;
            status_mpie_q <= status_mpie_d;
            mie_mtie_q    <= mie_mtie_d;
            mie_meie_q    <= mie_meie_d;
            mtip_q        <= mtip_d;
            meip_q        <= irq_i;
            mepc_q        <= mepc_d;
            mcause_int_q  <= mcause_int_d;
            mcause_code_q <= mcause_code_d;
        end
    end

    assign csr_mstatus_o = {24'd0, status_mpie_q, 3'd0, status_mie_q, 3'd0};
    assign csr_mie_o     = {20'd0, mie_meie_q, 3'd0, mie_mtie_q, 7'd0};
    assign csr_mip_o     = {20'd0, meip_q, 3'd0, mtip_q, 7'd0};
    assign csr_mepc_o    = mepc_q;
    assign csr_mcause_o  = {mcause_int_q, 27'd0, mcause_code_q};

    assign x_trap_o    = take_trap;
    assign x_mret_o    = take_mret;
    assign x_trap_pc_o = take_mret ? mepc_q : TRAP_VECTOR;

endmodule

// File: tb/tb_urv_trap_ctrl.sv
// Table-driven bench for urv_trap_ctrl: per-row stimulus with expected redirect outputs
// and expected CSR state, the latter queued at drive time and compared after the edge.
module tb_urv_trap_ctrl;

    logic        clk = 1'b0;
    logic        rst_i, x_stall_i, x_kill_i, x_valid_i, x_exception_i, x_is_mret_i;
    logic        d_is_csr_i, irq_i, timer_tick_i;
    logic [31:0] x_pc_i, x_csr_write_value_i;
    logic [3:0]  x_exception_cause_i;
    logic [11:0] d_csr_sel_i;
    logic [31:0] csr_mstatus_o, csr_mip_o, csr_mie_o, csr_mepc_o, csr_mcause_o, x_trap_pc_o;
    logic        x_trap_o, x_mret_o;

    always #5 clk = ~clk;

    urv_trap_ctrl #(
        .TRAP_VECTOR   (32'h0000_0008),
        .HOLDOFF_CYCLES(2)
    ) dut (
        .clk_i              (clk),
        .rst_i              (rst_i),
        .x_stall_i          (x_stall_i),
        .x_kill_i           (x_kill_i),
        .x_valid_i          (x_valid_i),
        .x_pc_i             (x_pc_i),
        .x_exception_i      (x_exception_i),
        .x_exception_cause_i(x_exception_cause_i),
        .x_is_mret_i        (x_is_mret_i),
        .d_is_csr_i         (d_is_csr_i),
        .d_csr_sel_i        (d_csr_sel_i),
        .x_csr_write_value_i(x_csr_write_value_i),
        .irq_i              (irq_i),
        .timer_tick_i       (timer_tick_i),
        .csr_mstatus_o      (csr_mstatus_o),
        .csr_mip_o          (csr_mip_o),
        .csr_mie_o          (csr_mie_o),
        .csr_mepc_o         (csr_mepc_o),
        .csr_mcause_o       (csr_mcause_o),
        .x_trap_o           (x_trap_o),
        .x_trap_pc_o        (x_trap_pc_o),
        .x_mret_o           (x_mret_o)
    );

    typedef struct {
        logic        rst, valid, stall, kill;
        logic [31:0] pc;
        logic        exc;
        logic [3:0]  cause;
        logic        mret, csr;
        logic [11:0] sel;
        logic [31:0] wv;
        logic        irq, tick;
        logic        e_trap, e_mret;
        logic [31:0] e_tpc, e_ms, e_me, e_mip, e_mepc, e_mc;
    } vec_t;

    typedef struct {
        logic [31:0] ms, me, mip, mepc, mc;
    } st_t;

    vec_t tbl[$];
    st_t  sb_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic vec_t mk(input logic rst, valid, stall, kill, input logic [31:0] pc,
                                input logic exc, input logic [3:0] cause, input logic mret,
                                input logic csr, input logic [11:0] sel, input logic [31:0] wv,
                                input logic irq, tick);
        vec_t v;
        v = '{default: '0};
        v.rst = rst; v.valid = valid; v.stall = stall; v.kill = kill; v.pc = pc;
        v.exc = exc; v.cause = cause; v.mret = mret; v.csr = csr; v.sel = sel; v.wv = wv;
        v.irq = irq; v.tick = tick;
        return v;
    endfunction

    function automatic vec_t ex(input vec_t v, input logic trap, mret, input logic [31:0] tpc,
                                input logic [31:0] ms, me, mip, mepc, mc);
        v.e_trap = trap; v.e_mret = mret; v.e_tpc = tpc;
        v.e_ms = ms; v.e_me = me; v.e_mip = mip; v.e_mepc = mepc; v.e_mc = mc;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        rst_i = v.rst; x_valid_i = v.valid; x_stall_i = v.stall; x_kill_i = v.kill;
        x_pc_i = v.pc; x_exception_i = v.exc; x_exception_cause_i = v.cause;
        x_is_mret_i = v.mret; d_is_csr_i = v.csr; d_csr_sel_i = v.sel;
        x_csr_write_value_i = v.wv; irq_i = v.irq; timer_tick_i = v.tick;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic apply(input int i, input vec_t v);
        st_t s;
        @(negedge clk);
        drive(v);
        #1;
        chk($sformatf("r%0d trap", i), {31'd0, x_trap_o}, {31'd0, v.e_trap});
        chk($sformatf("r%0d mret", i), {31'd0, x_mret_o}, {31'd0, v.e_mret});
        if (v.e_trap || v.e_mret) chk($sformatf("r%0d trap_pc", i), x_trap_pc_o, v.e_tpc);
        sb_q.push_back('{v.e_ms, v.e_me, v.e_mip, v.e_mepc, v.e_mc});
        @(posedge clk);
        #1;
        s = sb_q.pop_front();
        chk($sformatf("r%0d mstatus", i), csr_mstatus_o, s.ms);
        chk($sformatf("r%0d mie", i), csr_mie_o, s.me);
        chk($sformatf("r%0d mip", i), csr_mip_o, s.mip);
        chk($sformatf("r%0d mepc", i), csr_mepc_o, s.mepc);
        chk($sformatf("r%0d mcause", i), csr_mcause_o, s.mc);
    endtask

    initial begin
        vec_t v;
        int   k;

        drive(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        repeat (2) @(posedge clk);

        // rst, valid, stall, kill, pc, exc, cause, mret, csr, sel, wv, irq, tick
        // then: trap, mret, trap_pc, mstatus, mie, mip, mepc, mcause
        tbl.push_back(ex(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0),
                         0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(ex(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0),
                         0, 0, 0, 0, 0, 32'h800, 0, 0));
        tbl.push_back(ex(mk(0, 1, 0, 0, 32'h50, 0, 0, 0, 0, 0, 0, 1, 0),
                         0, 0, 0, 0, 0, 32'h800, 0, 0));
        tbl.push_back(ex(mk(0, 1, 0, 0, 32'h54, 0, 0, 0, 1, 12'h304, 32'hFFFF_FFFF, 1, 0),
                         0, 0, 0, 0, 32'h880, 32'h800, 0, 0));
        tbl.push_back(ex(mk(0, 1, 0, 0, 32'h58, 0, 0, 0, 1, 12'h300, 32'h8, 1, 0),
                         0, 0, 0, 32'h8, 32'h880, 32'h800, 0, 0));
        // external interrupt; the CSR write riding on the same instruction is dropped
        tbl.push_back(ex(mk(0, 1, 0, 0, 32'h100, 0, 0, 0, 1, 12'h341, 32'hDEAD_0000, 1, 0),
                         1, 0, 32'h8, 32'h80, 32'h880, 32'h800, 32'h100, 32'h8000_000B));
        tbl.push_back(ex(mk(0, 1, 0, 0, 32'h8, 0, 0, 0, 1, 12'h300, 32'h88, 1, 0),
                         0, 0, 0, 32'h88, 32'h880, 32'h800, 32'h100, 32'h8000_000B));
        // last holdoff cycle: enabled and pending, still not taken
        tbl.push_back(ex(mk(0, 1, 0, 0, 32'hC, 0, 0, 0, 0, 0, 0, 1, 0),
                         0, 0, 0, 32'h88, 32'h880, 32'h800, 32'h100, 32'h8000_000B));
        tbl.push_back(ex(mk(0, 1, 0, 0, 32'h204, 1, 4'd2, 0, 0, 0, 0, 1, 0),
                         1, 0, 32'h8, 32'h80, 32'h880, 32'h800, 32'h204, 32'h2));
        tbl.push_back(ex(mk(0, 1, 0, 0, 32'h208, 0, 0, 0, 1, 12'h341, 32'h101, 0, 0),
                         0, 0, 0, 32'h80, 32'h880, 0, 32'h100, 32'h2));
        tbl.push_back(ex(mk(0, 1, 0, 0, 32'h20C, 0, 0, 1, 0, 0, 0, 0, 0),
                         0, 1, 32'h100, 32'h88, 32'h880, 0, 32'h100, 32'h2));
        tbl.push_back(ex(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1),
                         0, 0, 0, 32'h88, 32'h880, 32'h80, 32'h100, 32'h2));
        tbl.push_back(ex(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0),
                         0, 0, 0, 32'h88, 32'h880, 32'h80, 32'h100, 32'h2));
        // timer trap with a simultaneous tick: latch stays set
        tbl.push_back(ex(mk(0, 1, 0, 0, 32'h300, 0, 0, 0, 0, 0, 0, 0, 1),
                         1, 0, 32'h8, 32'h80, 32'h880, 32'h80, 32'h300, 32'h8000_0007));
        tbl.push_back(ex(mk(0, 1, 0, 0, 32'h8, 0, 0, 0, 1, 12'h300, 32'h8, 0, 0),
                         0, 0, 0, 32'h8, 32'h880, 32'h80, 32'h300, 32'h8000_0007));
        tbl.push_back(ex(mk(0, 1, 0, 0, 32'hC, 0, 0, 0, 0, 0, 0, 0, 0),
                         0, 0, 0, 32'h8, 32'h880, 32'h80, 32'h300, 32'h8000_0007));
        tbl.push_back(ex(mk(0, 1, 0, 0, 32'h10, 0, 0, 0, 0, 0, 0, 0, 0),
                         1, 0, 32'h8, 32'h80, 32'h880, 0, 32'h10, 32'h8000_0007));
        tbl.push_back(ex(mk(0, 1, 1, 0, 32'h14, 0, 0, 0, 1, 12'h341, 32'h1234_5677, 0, 0),
                         0, 0, 0, 32'h80, 32'h880, 0, 32'h10, 32'h8000_0007));
        tbl.push_back(ex(mk(0, 1, 0, 1, 32'h14, 0, 0, 0, 1, 12'h341, 32'h1234_5677, 0, 0),
                         0, 0, 0, 32'h80, 32'h880, 0, 32'h10, 32'h8000_0007));
        tbl.push_back(ex(mk(0, 1, 0, 0, 32'h14, 0, 0, 0, 1, 12'h341, 32'h1234_5677, 0, 0),
                         0, 0, 0, 32'h80, 32'h880, 0, 32'h1234_5674, 32'h8000_0007));
        tbl.push_back(ex(mk(0, 1, 1, 0, 32'h40, 1, 4'd3, 0, 0, 0, 0, 0, 0),
                         0, 0, 0, 32'h80, 32'h880, 0, 32'h1234_5674, 32'h8000_0007));
        tbl.push_back(ex(mk(0, 1, 0, 0, 32'h44, 0, 0, 0, 1, 12'h342, 32'hFFFF_FFFF, 0, 0),
                         0, 0, 0, 32'h80, 32'h880, 0, 32'h1234_5674, 32'h8000_000F));
        tbl.push_back(ex(mk(0, 1, 0, 0, 32'h48, 0, 0, 0, 1, 12'h344, 32'hFFFF_FFFF, 0, 0),
                         0, 0, 0, 32'h80, 32'h880, 0, 32'h1234_5674, 32'h8000_000F));
        tbl.push_back(ex(mk(0, 1, 0, 0, 32'h4C, 0, 0, 0, 1, 12'h305, 32'hFFFF_FFFF, 0, 0),
                         0, 0, 0, 32'h80, 32'h880, 0, 32'h1234_5674, 32'h8000_000F));
        tbl.push_back(ex(mk(0, 1, 0, 0, 32'h50, 1, 4'd11, 0, 1, 12'h341, 32'h0, 0, 0),
                         1, 0, 32'h8, 32'h0, 32'h880, 0, 32'h50, 32'hB));
        // reset during a would-be trap, then back in RUN with nothing latched
        tbl.push_back(ex(mk(1, 1, 0, 0, 32'h60, 1, 4'd2, 0, 0, 0, 0, 1, 1),
                         0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(ex(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0),
                         0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(ex(mk(0, 1, 0, 0, 32'h0, 0, 0, 0, 1, 12'h304, 32'h880, 0, 0),
                         0, 0, 0, 0, 32'h880, 0, 0, 0));
        tbl.push_back(ex(mk(0, 1, 0, 0, 32'h4, 0, 0, 0, 1, 12'h300, 32'h8, 0, 0),
                         0, 0, 0, 32'h8, 32'h880, 0, 0, 0));

        foreach (tbl[i]) apply(i, tbl[i]);

        // irq rises with back-to-back commits: taken one cycle later via the MEIP register
        k = -1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            v = mk(0, 1, 0, 0, 32'(32'h70 + c * 4), 0, 0, 0, 0, 0, 0, 1, 0);
            drive(v);
            #1;
            if (x_trap_o && k < 0) k = c;
            @(posedge clk);
            #1;
            if (k >= 0) break;
        end
        chk("irq latency", 32'(k), 32'd1);
        chk("irq mepc", csr_mepc_o, 32'h74);
        chk("irq mcause", csr_mcause_o, 32'h8000_000B);
        chk("irq mstatus", csr_mstatus_o, 32'h80);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/urv_trap_ctrl.md
Name: urv_trap_ctrl

Overview:
- Machine-mode trap controller. Owns mstatus, mie, mip, mepc and mcause, and feeds them to the CSR read/modify datapath.
- Sequences trap entry for synchronous exceptions and interrupts, and trap return for MRET.
- Takes the CSR unit's computed write value to update its registers.
- Sits beside the execute stage and drives the pipeline redirect/kill for traps.

Parameters:
TRAP_VECTOR, 32'h00000008, PC loaded on any trap entry
HOLDOFF_CYCLES, 2, cycles after a trap entry or MRET during which interrupts are not taken (range 1..15)

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
x_stall_i  in  1  execute stage stalled; nothing commits
x_kill_i  in  1  instruction in X killed; nothing commits
x_valid_i  in  1  valid instruction present in X
x_pc_i  in  32  PC of instruction in X
x_exception_i  in  1  instruction in X raises synchronous exception
x_exception_cause_i  in  4  exception code (2 illegal, 3 ebreak, 11 ecall)
x_is_mret_i  in  1  instruction in X is MRET
d_is_csr_i  in  1  instruction in X is a CSR op
d_csr_sel_i  in  12  CSR address
x_csr_write_value_i  in  32  new CSR value from the CSR datapath
irq_i  in  1  external interrupt, level
timer_tick_i  in  1  timer compare pulse
csr_mstatus_o, csr_mip_o, csr_mie_o, csr_mepc_o, csr_mcause_o  out  32 each  CSR contents
x_trap_o  out  1  trap taken this cycle; kill X and redirect
x_trap_pc_o  out  32  redirect target (TRAP_VECTOR on trap entry, mepc on MRET)
x_mret_o  out  1  MRET committed this cycle; redirect to x_trap_pc_o

Behaviour:
- commit = x_valid_i & !x_stall_i & !x_kill_i. No state changes except MTIP/MEIP sampling when commit = 0.
- Register implementation:
  - mstatus: only bit3 (MIE) and bit7 (MPIE) implemented; other bits read 0.
  - mie: only bit7 (MTIE) and bit11 (MEIE) writable.
  - mip: bit7 MTIP = timer latch; bit11 MEIP = irq_i registered one cycle. mip is read-only.
  - mepc: bits[1:0] always 0.
  - mcause: bit31 is the interrupt flag, bits[3:0] the code; other bits 0.
- Reset: all CSR outputs 0, timer latch 0, MEIP 0, x_trap_o = x_mret_o = 0, FSM = RUN, holdoff counter 0.
- Interrupt request: int_req = mstatus.MIE & ((MEIP & MEIE) | (MTIP & MTIE)). External interrupt has priority over timer.
- Per-commit priority (highest first):
  1. exception: mepc ← x_pc_i; mcause ← {0, x_exception_cause_i}.
  2. interrupt (FSM = RUN only): mepc ← x_pc_i (the instruction is not executed). mcause ← 0x8000000B for external, 0x80000007 for timer. Timer trap clears the timer latch.
  3. mret: MIE ← MPIE; MPIE ← 1.
  4. CSR write.
- On cases 1 and 2:
  - MPIE ← MIE; MIE ← 0.
  - x_trap_o = 1 combinationally in the same cycle; x_trap_pc_o = TRAP_VECTOR.
  - Any CSR write from the same instruction is suppressed.
- On MRET: x_mret_o = 1 combinationally; x_trap_pc_o = csr_mepc_o (value before any update this cycle).
- CSR write on commit & d_is_csr_i & no trap:
  - Selected register takes x_csr_write_value_i, masked to implemented bits.
  - Writes to mip and to unlisted addresses are ignored.
  - The updated value is visible on the outputs the next cycle.
- FSM:
  - RUN → HOLDOFF on any trap entry or MRET; counter loads HOLDOFF_CYCLES-1.
  - HOLDOFF: counter decrements every clock regardless of stall; → RUN when the counter is 0.
  - Exceptions and MRET are still honoured in HOLDOFF; taking one reloads the counter.
- Timer latch:
  - Set by timer_tick_i, cleared by timer trap entry.
  - Simultaneous set and clear: set wins, latch stays 1.
- Reset asserted mid-HOLDOFF or during a trap cycle: everything returns to reset values next edge; no trap output.

Test Plan:
- Reset, then read all CSR outputs → all 0. Assert irq_i with MIE = 0 → no trap, mip reads 0x800 after 1 cycle.
- Write mie = 0x880 and mstatus = 0x8, irq_i = 1, commit PC 0x100 → x_trap_o = 1, x_trap_pc_o = 0x8, mepc = 0x100, mcause = 0x8000000B, mstatus = 0x80; no interrupt for the next HOLDOFF_CYCLES cycles.
- Illegal instruction (cause 2) at PC 0x204 while irq pending and enabled → exception wins: mcause = 0x2, mepc = 0x204.
- MRET with mepc = 0x100, mstatus = 0x80 → x_mret_o = 1, x_trap_pc_o = 0x100, mstatus = 0x88 next cycle.
- timer_tick_i in the same cycle as a timer trap entry → mip bit7 stays 1; second timer trap taken after holdoff expires.
- CSR write to mepc with value 0x12345677 while x_stall_i = 1 → no change; after stall drops, mepc = 0x12345674.
